// File: rtl/demux_l1.sv
// ---------------------------------------------------------------------------
// demux_l1 -- level-1 receive-side demultiplexer of the mux tree.
//
// Each input lane carries alternating words: even word first, odd word
// second. Every lane re-pairs its words and presents each pair on two
// output lanes in the same cycle. If a pair stays half-collected for
// TIMEOUT idle cycles, the held even word is flushed out on its own.
//
// Parameters
//   WIDTH    data width of every lane
//   TIMEOUT  idle cycles in HOLD before a partial pair is flushed (0 = never)
//   CNT_W    idle counter width, 2**CNT_W > TIMEOUT
//
// Ports
//   clk                   rising-edge clock
//   reset                 asynchronous active-low reset
//   Entrada0/1            lane-0/1 input word
//   validEntrada0/1       lane-0/1 word valid this cycle
//   Salida0/1             lane-0 even/odd word
//   Salida2/3             lane-1 even/odd word
//   validSalida0..3       one-cycle qualifiers for the matching Salida
//   flush0/1              one-cycle pulse: lane-0/1 partial pair flushed
// ---------------------------------------------------------------------------

// Single-lane pairing engine: EMPTY/HOLD FSM plus the idle-timeout counter.
module demux_l1_lane #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic [WIDTH-1:0] even,
    output logic [WIDTH-1:0] odd,
    output logic             valid_even,
    output logic             valid_odd,
    output logic             flush
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] hold;
    logic [CNT_W-1:0] idle_cnt;
    logic             expire;

    // The current idle cycle is the TIMEOUT-th one in a row, so the partial
    // pair is flushed on this edge. A valid word in the same cycle takes
    // priority in the FSM below and completes the pair instead.
    assign expire = (TIMEOUT > 0) && (idle_cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: every register here, the hold word included, is plain flops, not
    // a memory, so all of it is cleared by reset; a reset mid-pair therefore
    // discards the held word. Non-blocking assignments keep each flop's next
    // value based on the pre-edge state regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_EMPTY;
            hold       <= '0;
            idle_cnt   <= '0;
            even       <= '0;
            odd        <= '0;
            valid_even <= 1'b0;
            valid_odd  <= 1'b0;
            flush      <= 1'b0;
        end else begin
            // Qualifiers are single-cycle pulses; data outputs keep their value.
            valid_even <= 1'b0;
            valid_odd  <= 1'b0;
            flush      <= 1'b0;
            case (state)
                ST_EMPTY: begin
                    if (valid) begin
                        hold     <= data;
                        idle_cnt <= '0;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (valid) begin
                        even       <= hold;
                        odd        <= data;
                        valid_even <= 1'b1;
                        valid_odd  <= 1'b1;
                        state      <= ST_EMPTY;
                    end else if (expire) begin
                        even       <= hold;
                        valid_even <= 1'b1;
                        flush      <= 1'b1;
                        state      <= ST_EMPTY;
                    end else if (idle_cnt != {CNT_W{1'b1}}) begin
                        // Saturate so a disabled timeout never wraps around.
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

module demux_l1 #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Entrada0,
    input  logic             validEntrada0,
    input  logic [WIDTH-1:0] Entrada1,
    input  logic             validEntrada1,
    output logic [WIDTH-1:0] Salida0,
    output logic [WIDTH-1:0] Salida1,
    output logic [WIDTH-1:0] Salida2,
    output logic [WIDTH-1:0] Salida3,
    output logic             validSalida0,
    output logic             validSalida1,
    output logic             validSalida2,
    output logic             validSalida3,
    output logic             flush0,
    output logic             flush1
);

    // The two lanes share nothing but clock and reset.
    demux_l1_lane #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_lane0 (
        .clk        (clk),
        .reset      (reset),
        .data       (Entrada0),
        .valid      (validEntrada0),
        .even       (Salida0),
        .odd        (Salida1),
        .valid_even (validSalida0),
        .valid_odd  (validSalida1),
        .flush      (flush0)
    );

    demux_l1_lane #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_lane1 (
        .clk        (clk),
        .reset      (reset),
        .data       (Entrada1),
        .valid      (validEntrada1),
        .even       (Salida2),
        .odd        (Salida3),
        .valid_even (validSalida2),
        .valid_odd  (validSalida3),
        .flush      (flush1)
    );

endmodule

// File: tb/tb_demux_l1.sv
// ---------------------------------------------------------------------------
// tb_demux_l1 -- self-checking bench for demux_l1.
//
// The driver applies one input beat per cycle and feeds the same beat to a
// per-lane reference model (pending word + idle count). Every output the
// model predicts is queued with the cycle it is due; a monitor on the
// falling edge pops and compares whenever the DUT shows a valid or flush,
// and checks that data outputs hold their value in between.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_demux_l1;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] Entrada0, Entrada1;
    logic             validEntrada0, validEntrada1;
    logic [WIDTH-1:0] Salida0, Salida1, Salida2, Salida3;
    logic             validSalida0, validSalida1, validSalida2, validSalida3;
    logic             flush0, flush1;

    demux_l1 #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .Entrada0      (Entrada0),
        .validEntrada0 (validEntrada0),
        .Entrada1      (Entrada1),
        .validEntrada1 (validEntrada1),
        .Salida0       (Salida0),
        .Salida1       (Salida1),
        .Salida2       (Salida2),
        .Salida3       (Salida3),
        .validSalida0  (validSalida0),
        .validSalida1  (validSalida1),
        .validSalida2  (validSalida2),
        .validSalida3  (validSalida3),
        .flush0        (flush0),
        .flush1        (flush1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        int         due;
        logic [7:0] e;
        logic [7:0] o;
        logic       ve;
        logic       vo;
        logic       fl;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state per lane.
    bit         has [2];
    logic [7:0] held[2];
    int         idle[2];
    logic [7:0] last_o[2];

    // Monitor's view of what the data outputs should currently hold.
    logic [7:0] cur_e[2];
    logic [7:0] cur_o[2];

    task automatic push(input int lane, input exp_t x);
        if (lane == 0) q0.push_back(x);
        else           q1.push_back(x);
    endtask

    // One beat on one lane, judged purely from the pairing rules.
    task automatic model_step(input int lane, input bit v, input logic [7:0] d);
        exp_t x;
        if (!has[lane]) begin
            if (v) begin
                has[lane]  = 1'b1;
                held[lane] = d;
                idle[lane] = 0;
            end
        end else if (v) begin
            x = '{due: cyc + 1, e: held[lane], o: d, ve: 1'b1, vo: 1'b1, fl: 1'b0};
            push(lane, x);
            last_o[lane] = d;
            has[lane]    = 1'b0;
        end else begin
            idle[lane]++;
            if (TIMEOUT > 0 && idle[lane] == TIMEOUT) begin
                x = '{due: cyc + 1, e: held[lane], o: last_o[lane], ve: 1'b1, vo: 1'b0, fl: 1'b1};
                push(lane, x);
                has[lane] = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            has[l]    = 1'b0;
            held[l]   = '0;
            idle[l]   = 0;
            last_o[l] = '0;
            cur_e[l]  = '0;
            cur_o[l]  = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic mon_lane(input int lane, input logic [7:0] e, input logic [7:0] o,
                            input logic ve, input logic vo, input logic fl);
        exp_t h;
        bit   have;
        string tag;
        tag  = (lane == 0) ? "lane0" : "lane1";
        have = (lane == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) h = (lane == 0) ? q0[0] : q1[0];
        // Anything still queued past its due cycle was never presented.
        while (have && h.due < cyc) begin
            check({tag, " missing output due cycle"}, 32'(cyc), 32'(h.due));
            if (lane == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            have = (lane == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (have) h = (lane == 0) ? q0[0] : q1[0];
        end
        if (ve || vo || fl) begin
            if (!have || h.due != cyc) begin
                check({tag, " unexpected valid/flush {ve,vo,fl}"}, {29'd0, ve, vo, fl}, 32'd0);
            end else begin
                if (lane == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                check({tag, " valid/flush {ve,vo,fl}"}, {29'd0, ve, vo, fl}, {29'd0, h.ve, h.vo, h.fl});
                cur_e[lane] = h.e;
                cur_o[lane] = h.o;
            end
        end
        check({tag, " even data"}, 32'(e), 32'(cur_e[lane]));
        check({tag, " odd data"},  32'(o), 32'(cur_o[lane]));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon_lane(0, Salida0, Salida1, validSalida0, validSalida1, flush0);
            mon_lane(1, Salida2, Salida3, validSalida2, validSalida3, flush1);
        end
    end

    // -------------------------------------------------------------- driver
    task automatic drive(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
        validEntrada0 = v0;
        Entrada0      = d0;
        validEntrada1 = v1;
        Entrada1      = d1;
        model_step(0, v0, d0);
        model_step(1, v1, d1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    function automatic logic [39:0] all_outputs();
        return {Salida0, Salida1, Salida2, Salida3,
                validSalida0, validSalida1, validSalida2, validSalida3, flush0, flush1, 2'b00};
    endfunction

    // Pulse reset between clock edges and confirm outputs clear without an edge.
    task automatic pulse_reset(input string name);
        logic [39:0] snap;
        #2;
        reset = 1'b0;
        #1;
        snap = all_outputs();
        check({name, " outputs low"}, snap[39:8], 32'd0);
        check({name, " valids/flush low"}, {24'd0, snap[7:0]}, 32'd0);
        model_reset();
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [39:0] snap;
        reset         = 1'b0;
        Entrada0      = '0;
        Entrada1      = '0;
        validEntrada0 = 1'b0;
        validEntrada1 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        snap = all_outputs();
        check("reset data outputs", snap[39:8], 32'd0);
        check("reset valids/flush", {24'd0, snap[7:0]}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic pair on lane 0.
        drive(1'b1, 8'hA1, 1'b0, 8'h00);
        drive(1'b1, 8'hB2, 1'b0, 8'h00);
        idle_cycles(2);

        // Streaming on lane 1, lane 0 silent.
        drive(1'b0, 8'h00, 1'b1, 8'h10);
        drive(1'b0, 8'h00, 1'b1, 8'h11);
        drive(1'b0, 8'h00, 1'b1, 8'h12);
        drive(1'b0, 8'h00, 1'b1, 8'h13);
        idle_cycles(2);

        // Timeout flush, then the next word starts a fresh pair.
        drive(1'b1, 8'h5C, 1'b0, 8'h00);
        idle_cycles(TIMEOUT + 1);
        drive(1'b1, 8'h77, 1'b0, 8'h00);
        drive(1'b1, 8'h78, 1'b0, 8'h00);
        idle_cycles(2);

        // Race: completing word on the idle cycle that would expire.
        drive(1'b1, 8'h33, 1'b0, 8'h00);
        idle_cycles(TIMEOUT - 1);
        drive(1'b1, 8'h44, 1'b0, 8'h00);
        idle_cycles(TIMEOUT + 2);

        // Independence and reset mid-pair: 0x99 is held, lane 1 completes.
        drive(1'b1, 8'h99, 1'b1, 8'h01);
        drive(1'b0, 8'h00, 1'b1, 8'h02);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        pulse_reset("mid-pair reset");
        idle_cycles(TIMEOUT + 2);
        drive(1'b1, 8'h21, 1'b0, 8'h00);
        drive(1'b1, 8'h22, 1'b0, 8'h00);
        idle_cycles(2);

        // Randomised traffic on both lanes.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 40, 8'($urandom),
                  $urandom_range(0, 99) < 45, 8'($urandom));
        end
        idle_cycles(TIMEOUT + 3);

        check("lane0 scoreboard drained", 32'(q0.size()), 32'd0);
        check("lane1 scoreboard drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
